// File: rtl/snes_input_reader.sv
`default_nettype none
// ==========================================================================
// snes_input_reader : polls a SNES serial pad, outputs button state/press pulses
// Rev 1.0
// ==========================================================================
module snes_input_reader #(
  parameter int CLK_DIV     = 2,
  parameter int POLL_PERIOD = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        ser_data,
  output logic        ctrl_latch,
  output logic        ctrl_clk,
  output logic [0:11] buttons,
  output logic [0:11] buttons_pressed,
  output logic        valid
);

  localparam int WAIT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int PH_W   = $clog2(2 * CLK_DIV);

  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(POLL_PERIOD - 1);
  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_BIT_HIGH = 3'd2,
    ST_BIT_LOW  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [3:0]        idx_q, idx_d;
  logic [0:11]       shift_q, shift_d;
  logic [0:11]       buttons_q, buttons_d;
  logic [0:11]       pressed_q, pressed_d;
  logic              valid_q, valid_d;
  logic              ctrl_latch_q, ctrl_latch_d;
  logic              ctrl_clk_q, ctrl_clk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      buttons_q    <= '0;
      pressed_q    <= '0;
      valid_q      <= 1'b0;
      ctrl_latch_q <= 1'b0;
      ctrl_clk_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      buttons_q    <= buttons_d;
      pressed_q    <= pressed_d;
      valid_q      <= valid_d;
      ctrl_latch_q <= ctrl_latch_d;
      ctrl_clk_q   <= ctrl_clk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    pressed_d = '0;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (wait_q == WAIT_LAST) begin
            state_d = ST_LATCH;
            wait_d  = '0;
            phase_d = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = ST_BIT_HIGH;
          phase_d = '0;
          idx_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_BIT_HIGH: begin
        if (phase_q == HALF_LAST) begin
          // Pad drives active-low; bits 12-15 are clocked out but not kept
          if (idx_q < 4'd12) begin
            shift_d[idx_q] = ~ser_data;
          end
          state_d = ST_BIT_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_BIT_LOW: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (idx_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_BIT_HIGH;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        buttons_d = shift_q;
        pressed_d = shift_q & ~buttons_q;
        valid_d   = 1'b1;
        wait_d    = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free pad pins
  assign ctrl_latch_d = (state_d == ST_LATCH);
  assign ctrl_clk_d   = (state_d != ST_BIT_LOW);

  assign ctrl_latch      = ctrl_latch_q;
  assign ctrl_clk        = ctrl_clk_q;
  assign buttons         = buttons_q;
  assign buttons_pressed = pressed_q;
  assign valid           = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_input_reader.sv
`default_nettype none
// tb_snes_input_reader : pad model, event monitor, table and random frame checks
module tb_snes_input_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ser_data;
  logic        ctrl_latch;
  logic        ctrl_clk;
  logic [0:11] buttons;
  logic [0:11] buttons_pressed;
  logic        valid;

  always #5 clk = ~clk;

  snes_input_reader #(.CLK_DIV(2), .POLL_PERIOD(100)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .ser_data        (ser_data),
    .ctrl_latch      (ctrl_latch),
    .ctrl_clk        (ctrl_clk),
    .buttons         (buttons),
    .buttons_pressed (buttons_pressed),
    .valid           (valid)
  );

  // Pad model: latch loads, each ctrl_clk rising edge advances to the next bit
  logic [0:11] pad_btn;
  bit          pad_connected;
  int          pad_idx = 0;

  always @(posedge ctrl_latch or posedge ctrl_clk) begin
    if (ctrl_latch) pad_idx <= 0;
    else if (pad_idx < 16) pad_idx <= pad_idx + 1;
  end

  assign ser_data = (pad_connected && pad_idx < 12) ? ~pad_btn[pad_idx] : 1'b1;

  // Event monitor sampled 1 time unit after each rising clock edge
  int          cyc = 0;
  int          lat_cnt = 0, val_cnt = 0;
  int          lat_rise_cyc = 0, val_cyc = 0;
  int          latch_run = 0, clk_low_run = 0;
  int          latch_lens[$];
  int          clk_lows[$];
  int          stray = 0;
  logic        p_latch = 1'b0, p_clk = 1'b1;
  logic [0:11] p_buttons = '0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (ctrl_latch && !p_latch) begin lat_cnt++; lat_rise_cyc = cyc; end
    if (ctrl_latch) latch_run++;
    else if (p_latch) begin latch_lens.push_back(latch_run); latch_run = 0; end
    if (!ctrl_clk) clk_low_run++;
    else if (p_clk === 1'b0) begin clk_lows.push_back(clk_low_run); clk_low_run = 0; end
    if (valid) begin val_cnt++; val_cyc = cyc; end
    if (rst && !valid && (buttons !== p_buttons || buttons_pressed !== 12'h000)) stray++;
    p_latch   = ctrl_latch;
    p_clk     = ctrl_clk;
    p_buttons = buttons;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    int start;
    start = val_cnt;
    for (int i = 0; i < budget && val_cnt == start; i++) @(negedge clk);
    if (val_cnt == start) begin
      checks++; errors++;
      $display("FAIL wait_valid: no valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_latch(input int budget);
    int start;
    start = lat_cnt;
    for (int i = 0; i < budget && lat_cnt == start; i++) @(negedge clk);
    if (lat_cnt == start) begin
      checks++; errors++;
      $display("FAIL wait_latch: no latch within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [0:11] pad;
    logic [0:11] exp_btn;
    logic [0:11] exp_prs;
  } vec_t;

  vec_t        tbl[9];
  logic [0:11] model_prev;
  logic [0:11] exp_btn, exp_prs;
  int          en_cyc, first_rise, base_clk, bad, l1, v1, target;
  logic [31:0] r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{12'b1001_0000_1001, 12'b1001_0000_1001, 12'b1001_0000_1001};
    tbl[1] = '{12'b0000_0000_0000, 12'b0000_0000_0000, 12'b0000_0000_0000};
    tbl[2] = '{12'b1000_0000_0000, 12'b1000_0000_0000, 12'b1000_0000_0000};
    tbl[3] = '{12'b1000_0000_0000, 12'b1000_0000_0000, 12'b0000_0000_0000};
    tbl[4] = '{12'b1000_0000_0000, 12'b1000_0000_0000, 12'b0000_0000_0000};
    tbl[5] = '{12'b1000_1000_0000, 12'b1000_1000_0000, 12'b0000_1000_0000};
    tbl[6] = '{12'b0000_1000_0000, 12'b0000_1000_0000, 12'b0000_0000_0000};
    tbl[7] = '{12'b1000_1000_0000, 12'b1000_1000_0000, 12'b1000_0000_0000};
    tbl[8] = '{12'b1111_1111_1111, 12'b1111_1111_1111, 12'b0111_0111_1111};

    rst = 1'b0; enable = 1'b0; pad_btn = '0; pad_connected = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_latch", ctrl_latch, 1'b0);
    chk("rst_clk", ctrl_clk, 1'b1);
    chk("rst_buttons", buttons, 12'h000);
    chk("rst_pressed", buttons_pressed, 12'h000);
    chk("rst_valid", valid, 1'b0);

    // Idle with enable low: nothing happens
    rst = 1'b1;
    repeat (500) @(negedge clk);
    chk("idle_latch_count", lat_cnt, 0);
    chk("idle_valid_count", val_cnt, 0);
    chk("idle_latch", ctrl_latch, 1'b0);
    chk("idle_clk", ctrl_clk, 1'b1);
    chk("idle_buttons", buttons, 12'h000);

    // Frame timing with a disconnected pad
    base_clk = clk_lows.size();
    enable = 1'b1; en_cyc = cyc;
    wait_latch(200);
    chk("latch_delay", lat_rise_cyc - en_cyc, 100);
    wait_valid(200);
    chk("latch_to_valid", val_cyc - lat_rise_cyc, 69);
    chk("latch_len_count", latch_lens.size(), 1);
    if (latch_lens.size() > 0) chk("latch_len", latch_lens[0], 4);
    chk("clk_pulse_count", clk_lows.size() - base_clk, 16);
    bad = 0;
    for (int i = base_clk; i < clk_lows.size(); i++) if (clk_lows[i] != 2) bad++;
    chk("clk_pulse_width_bad", bad, 0);
    chk("disconnected_buttons", buttons, 12'h000);
    first_rise = lat_rise_cyc;
    wait_latch(300);
    chk("frame_period", lat_rise_cyc - first_rise, 169);
    wait_valid(200);

    // Table: decode and edge detection
    pad_connected = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pad_btn = tbl[i].pad;
      wait_valid(300);
      chk($sformatf("tbl%0d_buttons", i), buttons, tbl[i].exp_btn);
      chk($sformatf("tbl%0d_pressed", i), buttons_pressed, tbl[i].exp_prs);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid_off", i), valid, 1'b0);
      chk($sformatf("tbl%0d_pressed_off", i), buttons_pressed, 12'h000);
    end
    model_prev = tbl[8].exp_btn;

    // Random frames against the set-based model
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      pad_btn = r[11:0];
      pad_connected = ($urandom_range(0, 7) != 0);
      exp_btn = pad_connected ? pad_btn : 12'h000;
      exp_prs = exp_btn & ~model_prev;
      model_prev = exp_btn;
      wait_valid(300);
      chk($sformatf("rnd%0d_buttons", i), buttons, exp_btn);
      chk($sformatf("rnd%0d_pressed", i), buttons_pressed, exp_prs);
      @(negedge clk);
      chk($sformatf("rnd%0d_valid_off", i), valid, 1'b0);
    end

    // Enable dropped during BIT_LOW of bit 7
    pad_connected = 1'b1;
    pad_btn = 12'h5A5;
    wait_latch(300);
    target = lat_rise_cyc + 34;
    while (cyc < target) @(negedge clk);
    chk("drop_in_bit_low", ctrl_clk, 1'b0);
    enable = 1'b0;
    v1 = val_cnt;
    wait_valid(100);
    chk("drop_buttons", buttons, 12'h5A5);
    chk("drop_pressed", buttons_pressed, 12'h5A5 & ~model_prev);
    model_prev = 12'h5A5;
    l1 = lat_cnt;
    repeat (400) @(negedge clk);
    chk("drop_no_latch", lat_cnt - l1, 0);
    chk("drop_one_valid", val_cnt - v1, 1);
    enable = 1'b1; en_cyc = cyc;
    wait_latch(200);
    chk("reenable_latch_delay", lat_rise_cyc - en_cyc, 100);

    // Asynchronous reset in the middle of bit 5, all buttons held
    pad_btn = 12'hFFF;
    wait_valid(200);
    wait_latch(300);
    target = lat_rise_cyc + 24;
    while (cyc < target) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_latch", ctrl_latch, 1'b0);
    chk("arst_clk", ctrl_clk, 1'b1);
    chk("arst_buttons", buttons, 12'h000);
    chk("arst_pressed", buttons_pressed, 12'h000);
    chk("arst_valid", valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base_clk = clk_lows.size();
    wait_valid(400);
    chk("arst_next_buttons", buttons, 12'hFFF);
    chk("arst_next_pressed", buttons_pressed, 12'hFFF);
    chk("arst_next_latency", val_cyc - lat_rise_cyc, 69);
    chk("arst_next_bits", clk_lows.size() - base_clk, 16);

    chk("stray_output_changes", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snes_input_reader.md
Name: snes_input_reader

Overview:
- Upstream stage of game_controller: polls a SNES-style serial gamepad and drives the 12-bit controller_inputs vector.
- Generates the latch and serial-clock strobes and shifts in 16 serial bits, of which the first 12 are kept.
- Presents a stable, active-high button vector plus one-cycle "newly pressed" pulses and a frame-valid strobe.

Parameters:
- CLK_DIV, 2, clk cycles per ctrl_clk half-period; legal range is 1 or more.
- POLL_PERIOD, 100, clk cycles spent in IDLE between transactions; legal range is 1 or more.
- Counter widths are derived with $clog2 of these parameters.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  when high, permits new polls.
- ser_data  input  1  serial data from the pad; 0 means pressed.
- ctrl_latch  output  1  latch strobe to the pad, active high.
- ctrl_clk  output  1  serial clock to the pad; idles high.
- buttons  output  [0:11]  debounced-by-frame button state, 1 means pressed. Order: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
- buttons_pressed  output  [0:11]  one-cycle pulse for each rising edge of a button between frames.
- valid  output  1  one-cycle pulse when buttons updates.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; all counters clear to 0; the shift register clears.
  - ctrl_latch=0, ctrl_clk=1, buttons=0, buttons_pressed=0, valid=0.
  - An in-progress transaction is abandoned.
  - After release, the block starts in IDLE with the wait counter at 0.
- FSM states: IDLE, LATCH, BIT_HIGH, BIT_LOW, DONE.
- IDLE:
  - ctrl_latch=0, ctrl_clk=1.
  - The wait counter increments each cycle while enable=1 and holds while enable=0.
  - When the counter reaches POLL_PERIOD-1 with enable=1, go to LATCH and clear the counter.
- LATCH:
  - ctrl_latch=1 for exactly 2*CLK_DIV cycles, then go to BIT_HIGH with bit index 0.
- BIT_HIGH:
  - ctrl_clk=1 for CLK_DIV cycles.
  - On the last cycle, sample ~ser_data into shift bit [index]; indices 12-15 are sampled and discarded.
  - Then go to BIT_LOW.
- BIT_LOW:
  - ctrl_clk=0 for CLK_DIV cycles.
  - Then if index=15, go to DONE; otherwise increment index and go to BIT_HIGH.
  - The rising edge of ctrl_clk is what advances the pad's shift register.
- DONE (1 cycle):
  - buttons <= shift[0:11].
  - buttons_pressed <= shift[0:11] & ~buttons (old value).
  - valid <= 1.
  - Then go to IDLE and clear the wait counter.
- Output timing:
  - buttons_pressed and valid are registered.
  - Both are high for exactly the one cycle after the DONE edge, and 0 at all other times.
- Transaction length: LATCH through DONE takes 34*CLK_DIV + 1 cycles. Frame period = POLL_PERIOD + 34*CLK_DIV + 1 with enable held high.
- buttons holds its value between frames; it changes only on the DONE update.
- enable deasserted mid-transaction: the transaction completes normally and the block then waits in IDLE.
- A button held across frames gives no repeat pulse. A release sets no pulse. Release and press in separate frames gives a new pulse.
- A disconnected pad (ser_data pulled high) reads as all released.
- Bit index is 4 bits and does not wrap past 15; the exit check occurs at 15.

Test Plan (CLK_DIV=2, POLL_PERIOD=100):
- Reset/idle: rst low then high, enable=0 for 500 cycles.
  - Required: ctrl_latch=0, ctrl_clk=1, buttons=0, valid never pulses.
- Timing: enable=1, ser_data=1.
  - Required: first ctrl_latch rise 100 cycles after enable; latch high 4 cycles; exactly 16 ctrl_clk low pulses of 2 cycles each; valid 69 cycles after latch rise.
  - Required: frame period 169 cycles.
- Decode: pad model drives 0 for B, Start, A, R (bits 0, 3, 8, 11).
  - Required: buttons=12'b1001_0000_1001 in [0:11] order; buttons_pressed equals the same pattern for 1 cycle.
- Edge detect: hold B for 3 frames, then add Up.
  - Required: buttons_pressed[0] pulses only in frame 1; buttons_pressed[4] pulses only in frame 4; buttons[0] stays 1 throughout.
- Enable drop: deassert enable during BIT_LOW of bit 7.
  - Required: the frame finishes and valid pulses once; no further latch occurs until enable is reasserted, then the next latch comes 100 cycles later.
- Async reset mid-frame: assert rst during bit 5 of a frame where all buttons are pressed, between clock edges.
  - Required: outputs go to reset values immediately; the next frame after release performs a full 16-bit read; buttons_pressed=12'hFFF.
